// File: rtl/acc_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : acc_shift_ctrl
// Description : Requantises tile accumulator pairs with a per-channel shift,
//               optional round-half-up and saturation to the activation width.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_shift_ctrl #(
    parameter int DW  = 22,
    parameter int OW  = 8,
    parameter int NCH = 8,
    parameter int CW  = 3,
    parameter int LW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_addr,
    input  logic [2:0]    cfg_shift,
    input  logic          cfg_rnd,
    input  logic          start,
    input  logic [LW-1:0] n_pairs,
    input  logic          m_valid,
    output logic          m_ready,
    input  logic [DW-1:0] m_data1,
    input  logic [DW-1:0] m_data2,
    output logic          s_valid,
    input  logic          s_ready,
    output logic [OW-1:0] s_data1,
    output logic [OW-1:0] s_data2,
    output logic [CW-1:0] s_ch,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic signed [DW:0] SAT_MAX = (DW+1)'((64'sd1 <<< (OW-1)) - 64'sd1);
    localparam logic signed [DW:0] SAT_MIN = -SAT_MAX - (DW+1)'(1);

    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] ch_q, ch_d;
    logic          rnd_q, rnd_d;
    logic [2:0]    shift_tbl_q [NCH];
    logic [2:0]    shift_tbl_d [NCH];
    logic          s_valid_q, s_valid_d;
    logic [OW-1:0] s_data1_q, s_data1_d;
    logic [OW-1:0] s_data2_q, s_data2_d;
    logic [CW-1:0] s_ch_q, s_ch_d;
    logic          done_q, done_d;

    logic          m_ready_w;
    logic          accept_w;
    logic          out_fire_w;
    logic [2:0]    cur_shift_w;

    // Sign-extend by one bit so the rounding bias can never overflow.
    function automatic logic [OW-1:0] requant(
        input logic [DW-1:0] x,
        input logic [2:0]    n,
        input logic          rnd
    );
        logic signed [DW:0] xe;
        logic signed [DW:0] bias;
        logic signed [DW:0] y;
        xe   = $signed({x[DW-1], x});
        bias = (rnd && (n != 3'd0)) ? ((DW+1)'(1) << (n - 3'd1)) : '0;
        y    = (xe + bias) >>> n;
        if (y > SAT_MAX) begin
            y = SAT_MAX;
        end else if (y < SAT_MIN) begin
            y = SAT_MIN;
        end
        return y[OW-1:0];
    endfunction

    assign m_ready_w   = (state_q == ST_RUN) && (!s_valid_q || s_ready);
    assign accept_w    = m_valid && m_ready_w;
    assign out_fire_w  = s_valid_q && s_ready;
    assign cur_shift_w = shift_tbl_q[ch_q];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        rnd_d       = rnd_q;
        shift_tbl_d = shift_tbl_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    shift_tbl_d[cfg_addr] = cfg_shift;
                    rnd_d                 = cfg_rnd;
                end
                if (start) begin
                    if (n_pairs != '0) begin
                        state_d = ST_RUN;
                        cnt_d   = n_pairs;
                        ch_d    = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept_w) begin
                    cnt_d = cnt_q - LW'(1);
                    ch_d  = (ch_q == CW'(NCH-1)) ? '0 : ch_q + CW'(1);
                    if (cnt_q == LW'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!s_valid_q || out_fire_w) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: a new beat reloads it even while the old one is leaving.
    always_comb begin
        s_valid_d = s_valid_q;
        s_data1_d = s_data1_q;
        s_data2_d = s_data2_q;
        s_ch_d    = s_ch_q;
        if (accept_w) begin
            s_valid_d = 1'b1;
            s_data1_d = requant(m_data1, cur_shift_w, rnd_q);
            s_data2_d = requant(m_data2, cur_shift_w, rnd_q);
            s_ch_d    = ch_q;
        end else if (out_fire_w) begin
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            rnd_q     <= 1'b0;
            s_valid_q <= 1'b0;
            s_data1_q <= '0;
            s_data2_q <= '0;
            s_ch_q    <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shift_tbl_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            rnd_q       <= rnd_d;
            s_valid_q   <= s_valid_d;
            s_data1_q   <= s_data1_d;
            s_data2_q   <= s_data2_d;
            s_ch_q      <= s_ch_d;
            done_q      <= done_d;
            shift_tbl_q <= shift_tbl_d;
        end
    end

    assign m_ready = m_ready_w;
    assign s_valid = s_valid_q;
    assign s_data1 = s_data1_q;
    assign s_data2 = s_data2_q;
    assign s_ch    = s_ch_q;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_shift_ctrl
// Description : Scoreboard bench for acc_shift_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_shift_ctrl;

    localparam int DW  = 22;
    localparam int OW  = 8;
    localparam int NCH = 8;
    localparam int CW  = 3;
    localparam int LW  = 16;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [CW-1:0] cfg_addr;
    logic [2:0]    cfg_shift;
    logic          cfg_rnd;
    logic          start;
    logic [LW-1:0] n_pairs;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data1;
    logic [DW-1:0] m_data2;
    logic          s_valid;
    logic          s_ready;
    logic [OW-1:0] s_data1;
    logic [OW-1:0] s_data2;
    logic [CW-1:0] s_ch;
    logic          busy;
    logic          done;

    acc_shift_ctrl #(.DW(DW), .OW(OW), .NCH(NCH), .CW(CW), .LW(LW)) u_dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_shift(cfg_shift), .cfg_rnd(cfg_rnd),
        .start(start), .n_pairs(n_pairs),
        .m_valid(m_valid), .m_ready(m_ready), .m_data1(m_data1), .m_data2(m_data2),
        .s_valid(s_valid), .s_ready(s_ready), .s_data1(s_data1), .s_data2(s_data2),
        .s_ch(s_ch), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint d1;
        longint d2;
        int     ch;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     tbl_m [NCH];
    bit     rnd_m;
    int     ch_m;
    int     done_cnt = 0;
    bit     tog_en = 0;
    int     tog_idx = 0;
    int     tog_pat [4] = '{1, 0, 0, 1};
    bit     rdy_level = 1;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Floor division written out explicitly, then clamp to the signed OW range.
    function automatic longint model_q(input longint x, input int n, input bit r);
        longint num, den, q, hi, lo;
        hi  = (64'sd1 <<< (OW-1)) - 1;
        lo  = -(64'sd1 <<< (OW-1));
        num = x + ((r && n > 0) ? (64'sd1 <<< (n-1)) : 64'sd0);
        den = 64'sd1 <<< n;
        q   = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q;
    endfunction

    always @(posedge clk) begin
        #1;
        if (tog_en) begin
            s_ready = tog_pat[tog_idx % 4] != 0;
            tog_idx++;
        end else begin
            s_ready = rdy_level;
        end
    end

    // Output monitor: pops the scoreboard on every output handshake.
    logic [OW-1:0] held1, held2;
    bit            stalled = 0;
    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (!rst) begin
            if (stalled) begin
                check_val("hold_valid", s_valid, 1);
                check_val("hold_d1", $signed(s_data1), $signed(held1));
                check_val("hold_d2", $signed(s_data2), $signed(held2));
            end
            if (s_valid && s_ready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("out_d1", $signed(s_data1), e.d1);
                    check_val("out_d2", $signed(s_data2), e.d2);
                    check_val("out_ch", s_ch, e.ch);
                end
            end
            stalled = s_valid && !s_ready;
            if (stalled) begin
                held1 = s_data1;
                held2 = s_data2;
                check_val("stall_mready", m_ready, 0);
            end
        end else begin
            stalled = 0;
        end
    end

    task automatic cfg_write(input int addr, input int sh, input bit r);
        cfg_we = 1; cfg_addr = CW'(addr); cfg_shift = 3'(sh); cfg_rnd = r;
        @(posedge clk); #1;
        cfg_we = 0;
        tbl_m[addr] = sh;
        rnd_m = r;
    endtask

    task automatic start_tile(input int n);
        start = 1; n_pairs = LW'(n);
        @(posedge clk); #1;
        start = 0;
        ch_m = 0;
    endtask

    task automatic send(input longint d1, input longint d2);
        bit ok = 0;
        int acc_ch = 0;
        m_valid = 1; m_data1 = DW'(d1); m_data2 = DW'(d2);
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clk);
            if (m_ready) begin
                exp_t e;
                e.d1 = model_q(d1, tbl_m[ch_m], rnd_m);
                e.d2 = model_q(d2, tbl_m[ch_m], rnd_m);
                e.ch = ch_m;
                sb.push_back(e);
                acc_ch = ch_m;
                ch_m = (ch_m == NCH-1) ? 0 : ch_m + 1;
                ok = 1;
            end
            @(posedge clk); #1;
        end
        if (!ok) check_val("send_timeout", 0, 1);
        else begin
            check_val("lat_valid", s_valid, 1);
            check_val("lat_ch", s_ch, acc_ch);
        end
    endtask

    task automatic wait_done(input int base);
        for (int w = 0; w < 300 && done_cnt == base; w++) begin
            @(negedge clk); #1;
        end
        check_val("done_seen", (done_cnt > base) ? 1 : 0, 1);
        check_val("sb_empty", sb.size(), 0);
        repeat (3) @(negedge clk);
        #1;
        check_val("done_once", done_cnt - base, 1);
        check_val("idle_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        rst = 1; cfg_we = 0; cfg_addr = '0; cfg_shift = '0; cfg_rnd = 0;
        start = 0; n_pairs = '0; m_valid = 0; m_data1 = '0; m_data2 = '0;
        for (int i = 0; i < NCH; i++) tbl_m[i] = 0;
        rnd_m = 0; ch_m = 0;
        repeat (2) @(negedge clk);
        check_val("rst_s_valid", s_valid, 0);
        check_val("rst_s_data1", s_data1, 0);
        check_val("rst_s_data2", s_data2, 0);
        check_val("rst_s_ch", s_ch, 0);
        check_val("rst_done", done, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_m_ready", m_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // Shifts 0..7 on a constant input, no rounding.
        for (int i = 0; i < NCH; i++) cfg_write(i, i, 0);
        base = done_cnt;
        start_tile(8);
        check_val("run_busy", busy, 1);
        for (int i = 0; i < 8; i++) send(-100, 300);
        m_valid = 0;
        wait_done(base);

        // Rounding and saturation.
        for (int i = 0; i < NCH; i++) cfg_write(i, 2, 1);
        base = done_cnt;
        start_tile(NCH);
        for (int i = 0; i < NCH; i++) send(6, -6);
        m_valid = 0;
        wait_done(base);
        cfg_write(0, 0, 1);
        base = done_cnt;
        start_tile(2);
        send(1000, -1000);
        send(-1000, 5);
        m_valid = 0;
        wait_done(base);

        // Backpressure with s_ready 1,0,0,1.
        for (int i = 0; i < NCH; i++) cfg_write(i, 1, 0);
        base = done_cnt;
        start_tile(4);
        tog_idx = 0; tog_en = 1;
        send(40, -41); send(-77, 90); send(255, -255); send(3, -3);
        m_valid = 0;
        wait_done(base);
        tog_en = 0;
        @(posedge clk); #1;

        // Channel wrap over a 10-beat tile, then an extra beat that must be refused.
        base = done_cnt;
        start_tile(10);
        for (int i = 0; i < 10; i++) send(i * 10 - 40, 100 - i * 7);
        m_data1 = DW'(99); m_data2 = DW'(99);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("extra_mready", m_ready, 0);
        end
        @(posedge clk); #1;
        m_valid = 0;
        wait_done(base);

        // Config writes and start pulses during a tile are ignored.
        base = done_cnt;
        start_tile(8);
        send(100, -100); send(100, -100); send(100, -100);
        cfg_we = 1; cfg_addr = 3'd3; cfg_shift = 3'd7; cfg_rnd = 1;
        start = 1; n_pairs = LW'(5);
        send(100, -100);
        cfg_we = 0; start = 0;
        for (int i = 0; i < 4; i++) send(100, -100);
        m_valid = 0;
        wait_done(base);

        // Zero-length tile.
        base = done_cnt;
        start_tile(0);
        @(negedge clk);
        check_val("zero_done", done, 1);
        check_val("zero_busy", busy, 0);
        @(negedge clk);
        check_val("zero_done_end", done, 0);
        @(posedge clk); #1;

        // Asynchronous reset mid-tile.
        for (int i = 0; i < NCH; i++) cfg_write(i, 3, 0);
        start_tile(8);
        send(80, -80); send(80, -80); send(80, -80);
        m_valid = 0;
        #2;
        rst = 1;
        #1;
        check_val("arst_s_valid", s_valid, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_m_ready", m_ready, 0);
        check_val("arst_done", done, 0);
        sb.delete();
        for (int i = 0; i < NCH; i++) tbl_m[i] = 0;
        rnd_m = 0;
        @(posedge clk); #1;
        rst = 0;
        base = done_cnt;
        repeat (3) @(negedge clk);
        check_val("arst_no_done", done_cnt - base, 0);
        @(posedge clk); #1;
        base = done_cnt;
        start_tile(2);
        send(50, -300);
        send(-7, 200);
        m_valid = 0;
        wait_done(base);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/acc_shift_ctrl.md
Name: acc_shift_ctrl

Overview:
- Sequences the accumulator requantisation stage at the end of a conv tile.
- Streams pairs of signed accumulator values through a valid/ready interface and applies a per-channel arithmetic right shift, looked up from a small config table.
- Optionally rounds the shifted value, then saturates it to the activation width.
- Counts beats per tile and signals completion. Sits between the PE accumulator bank and the output writeback.

Parameters:
DW, 22, accumulator data width (signed)
OW, 8, output activation width (signed)
NCH, 8, channels per group; the channel index wraps at NCH-1
CW, 3, channel index width, clog2(NCH)
LW, 16, tile length counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  shift table write strobe (honoured only in IDLE)
cfg_addr  in  CW  table entry index
cfg_shift  in  3  shift amount 0..7
cfg_rnd  in  1  global round-half-up enable (written with any cfg_we)
start  in  1  start pulse; sampled only in IDLE
n_pairs  in  LW  number of beats in the tile, captured on start
m_valid  in  1  input pair valid
m_ready  out  1  input pair ready
m_data1  in  DW  signed accumulator, lane 1
m_data2  in  DW  signed accumulator, lane 2
s_valid  out  1  output pair valid
s_ready  in  1  downstream ready
s_data1  out  OW  requantised lane 1
s_data2  out  OW  requantised lane 2
s_ch  out  CW  channel index of the output pair
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when the tile completes

Behaviour:
- Reset values (asynchronous): state=IDLE; shift table all 0; rnd=0; beat counter=0; channel index=0.
- Reset values of outputs: s_valid=0, s_data1/2=0, s_ch=0, done=0, busy=0, m_ready=0.
- Reset mid-tile aborts the tile immediately. No done pulse is produced.

States:
- IDLE: cfg_we writes table[cfg_addr]=cfg_shift and rnd=cfg_rnd.
  - start with n_pairs>0 -> RUN. Capture cnt=n_pairs and set ch=0.
  - start with n_pairs==0 -> stay in IDLE and pulse done on the next cycle.
- RUN: m_ready = !s_valid || s_ready.
  - Accept a beat when m_valid && m_ready: cnt-=1 and ch = (ch==NCH-1) ? 0 : ch+1.
  - On acceptance of the beat that takes cnt to 0 -> DRAIN.
- DRAIN: m_ready=0. When s_valid==0, or the final beat handshakes (s_valid && s_ready), -> IDLE and done=1 for one cycle.

General rules:
- cfg_we outside IDLE is ignored. The table is frozen for the whole tile.
- start outside IDLE is ignored.
- m_ready is 0 in IDLE and DRAIN. m_valid is ignored there.

Datapath (one register stage):
- Latency: a beat accepted at edge t appears with s_valid=1 after edge t, carrying its ch as s_ch.
- Throughput: 1 beat/cycle while s_ready=1.
- s_valid clears on s_valid && s_ready when no new beat is accepted in the same cycle.
- Simultaneous output handshake and input acceptance reloads the output register; there is no bubble.
- s_data* hold stable while s_valid && !s_ready.
- Shift per lane, with n=table[ch]:
  - If rnd && n>0: y = (x + 2^(n-1)) >>> n, computed in DW+1 bits so that no overflow occurs.
  - Otherwise: y = x >>> n. This is an arithmetic shift, so it floors toward negative infinity.
- Saturation: y > 2^(OW-1)-1 -> 2^(OW-1)-1; y < -2^(OW-1) -> -2^(OW-1); otherwise y is truncated to OW bits.
- Both lanes use the same n and the same rnd.

Boundaries:
- Channel index wraps after NCH-1, so with NCH=8 the 9th beat uses ch 0.
- LW counter: n_pairs = 2^LW-1 must be supported.

Test Plan:
- Config table[0..7]=0..7, rnd=0, start n_pairs=8, m_data1=-100 every beat, s_ready=1 -> outputs -100 (saturates to -100? no: -100 fits), -50, -25, -13, -7, -4, -2, -1. Each arrives 1 cycle after its accept; s_ch=0..7; done pulses once after the 8th output.
- rnd=1, table[0]=2, NCH beats with data1=6, data2=-6 -> outputs 2 and -1. Data1=1000 with table[0]=0 -> output saturates to 127; data1=-1000 -> output -128.
- s_ready toggling 1,0,0,1 during a 4-beat tile -> no beat is lost or duplicated, s_data is held while stalled, m_ready=0 whenever s_valid && !s_ready.
- Tile length 10, NCH=8 -> s_ch sequence 0..7,0,1. Beat 11 presented with m_valid=1 is not accepted (m_ready=0 in DRAIN/IDLE).
- cfg_we during RUN (table[3]=7) -> ignored, beats on ch 3 keep the old shift. start while busy is ignored. start with n_pairs=0 -> done on the next cycle, busy stays 0.
- rst asserted mid-tile after 3 of 8 beats -> state IDLE, s_valid=0, table cleared, no done pulse. A new start n_pairs=2 then runs normally with shift 0.
